sequencia_ctrl: RTL and testbench

Search controller for the 8-bit serial sequence detector. It accepts a search command (pattern plus bit budget), resets, loads and arms the detector, then serialises a byte stream MSB-first into it at one bit per cycle. It reports whether and where the pattern ended, or why the search stopped. It sits between the byte-oriented data source and the bit-serial detector, and owns the detector's reset, load and start lines.

---
 rtl/sequencia_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_sequencia_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequencia_ctrl.sv
// sequencia_ctrl: search controller for an 8-bit bit-serial sequence detector.
// Takes one search command (pattern + bit budget), resets/loads/arms the
// detector, then shifts the byte stream into it MSB-first at one bit per
// cycle. Reports a match position, starvation, or abort with a done pulse.
module sequencia_ctrl #(
  parameter int unsigned FOUND_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_pattern,
  input  logic [15:0] cmd_max_bits,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        det_rst_n,
  output logic        det_set_word,
  output logic [7:0]  det_word,
  output logic        det_start,
  output logic        det_bit,
  input  logic        det_found,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic        underrun,
  output logic [15:0] match_pos
);

  typedef enum logic [2:0] {
    IDLE, DRST, LOAD, ARM, FILL, STREAM, DRAIN, REPORT
  } state_e;

  localparam logic [7:0]  DRAIN_LAST = 8'(FOUND_LAT - 1);
  localparam logic [15:0] LAT16      = 16'(FOUND_LAT);

  state_e      state_q, state_d;
  logic [7:0]  pattern_q, pattern_d;
  logic [15:0] max_bits_q, max_bits_d;
  logic [15:0] bit_idx_q, bit_idx_d;      // index of the bit presented this cycle
  logic [13:0] bytes_q, bytes_d;          // bytes accepted in this search
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_pos_q, bit_pos_d;      // position of the current bit within its byte
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic [7:0]  drain_q, drain_d;
  logic        found_q, found_d;
  logic        underrun_q, underrun_d;
  logic [15:0] match_pos_q, match_pos_d;

  logic more_bytes, accept, last_bit, byte_end;

  // A byte is wanted only while the stream still needs bits beyond those already accepted.
  assign more_bytes = {bytes_q, 3'b000} < {1'b0, max_bits_q};
  assign in_ready   = !hold_vld_q && (state_q == FILL || state_q == STREAM) && more_bytes;
  assign accept     = in_valid && in_ready;
  assign last_bit   = (bit_idx_q + 16'd1) == max_bits_q;
  assign byte_end   = bit_pos_q == 3'd7;

  assign cmd_ready    = state_q == IDLE;
  assign busy         = state_q != IDLE;
  assign done         = state_q == REPORT;
  assign det_rst_n    = !(rst || state_q == DRST);
  assign det_set_word = state_q == LOAD;
  assign det_word     = (state_q == LOAD) ? pattern_q : 8'h00;
  assign det_start    = state_q == ARM;
  assign det_bit      = (state_q == STREAM) ? shift_q[7] : 1'b0;
  assign found        = found_q;
  assign underrun     = underrun_q;
  assign match_pos    = match_pos_q;

  // State register and datapath registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pattern_q   <= 8'h00;
      max_bits_q  <= 16'h0000;
      bit_idx_q   <= 16'h0000;
      bytes_q     <= 14'h0000;
      shift_q     <= 8'h00;
      bit_pos_q   <= 3'd0;
      hold_q      <= 8'h00;
      hold_vld_q  <= 1'b0;
      drain_q     <= 8'h00;
      found_q     <= 1'b0;
      underrun_q  <= 1'b0;
      match_pos_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      max_bits_q  <= max_bits_d;
      bit_idx_q   <= bit_idx_d;
      bytes_q     <= bytes_d;
      shift_q     <= shift_d;
      bit_pos_q   <= bit_pos_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      drain_q     <= drain_d;
      found_q     <= found_d;
      underrun_q  <= underrun_d;
      match_pos_q <= match_pos_d;
    end
  end

  // Next-state logic: sequencing, serialisation, intake and result capture.
  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    pattern_d   = pattern_q;
    max_bits_d  = max_bits_q;
    bit_idx_d   = bit_idx_q;
    bytes_d     = bytes_q;
    shift_d     = shift_q;
    bit_pos_d   = bit_pos_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    drain_d     = drain_q;
    found_d     = found_q;
    underrun_d  = underrun_q;
    match_pos_d = match_pos_q;

    if (accept) bytes_d = bytes_q + 14'd1;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pattern_d  = cmd_pattern;
          max_bits_d = cmd_max_bits;
          bit_idx_d  = 16'h0000;
          bytes_d    = 14'h0000;
          shift_d    = 8'h00;
          bit_pos_d  = 3'd0;
          hold_vld_d = 1'b0;
          drain_d    = 8'h00;
          state_d    = DRST;
        end
      end
      DRST: state_d = LOAD;
      LOAD: begin
        if (max_bits_q == 16'h0000) begin
          found_d    = 1'b0;
          underrun_d = 1'b0;
          state_d    = REPORT;
        end else begin
          state_d = ARM;
        end
      end
      ARM: state_d = FILL;
      FILL: begin
        if (accept) begin
          shift_d   = in_data;
          bit_pos_d = 3'd0;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        bit_idx_d = bit_idx_q + 16'd1;
        shift_d   = {shift_q[6:0], 1'b0};
        bit_pos_d = bit_pos_q + 3'd1;
        if (det_found) begin
          found_d     = 1'b1;
          underrun_d  = 1'b0;
          match_pos_d = bit_idx_q - LAT16;
          state_d     = REPORT;
        end else if (last_bit) begin
          drain_d = 8'h00;
          state_d = DRAIN;
        end else if (byte_end) begin
          // Reload from the hold register, or straight from a byte arriving now.
          if (hold_vld_q) begin
            shift_d    = hold_q;
            hold_vld_d = 1'b0;
          end else if (accept) begin
            shift_d = in_data;
          end else begin
            found_d    = 1'b0;
            underrun_d = 1'b1;
            state_d    = REPORT;
          end
        end else if (accept) begin
          hold_d     = in_data;
          hold_vld_d = 1'b1;
        end
      end
      DRAIN: begin
        bit_idx_d = bit_idx_q + 16'd1;
        if (det_found) begin
          found_d     = 1'b1;
          underrun_d  = 1'b0;
          match_pos_d = bit_idx_q - LAT16;
          state_d     = REPORT;
        end else if (drain_q == DRAIN_LAST) begin
          found_d    = 1'b0;
          underrun_d = 1'b0;
          state_d    = REPORT;
        end else begin
          drain_d = drain_q + 8'd1;
        end
      end
      REPORT: begin
        hold_vld_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over every other cause and leaves the previous match position.
    if (abort && state_q != IDLE && state_q != REPORT) begin
      found_d     = 1'b0;
      underrun_d  = 1'b0;
      match_pos_d = match_pos_q;
      state_d     = REPORT;
    end
  end

endmodule

// File: tb/tb_sequencia_ctrl.sv
// Bench for sequencia_ctrl: a behavioural detector model, a byte source fed
// from a queue, and a done-triggered monitor that checks results against a
// scoreboard of expected outcomes pushed before each command.
module tb_sequencia_ctrl;
  localparam int FOUND_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_pattern = 8'h00;
  logic [15:0] cmd_max_bits = 16'h0000;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        det_rst_n, det_set_word, det_start, det_bit, det_found;
  logic [7:0]  det_word;
  logic        busy, done, found, underrun;
  logic [15:0] match_pos;

  always #5 clk = ~clk;

  sequencia_ctrl #(.FOUND_LAT(FOUND_LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_pattern(cmd_pattern), .cmd_max_bits(cmd_max_bits),
    .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .det_rst_n(det_rst_n), .det_set_word(det_set_word), .det_word(det_word),
    .det_start(det_start), .det_bit(det_bit), .det_found(det_found),
    .busy(busy), .done(done), .found(found), .underrun(underrun),
    .match_pos(match_pos)
  );

  // Detector model: bit presented in cycle c shows up as det_found in c+2.
  logic [7:0] m_word = 8'h00, m_sreg = 8'h00;
  logic       m_armed = 1'b0, m_fnd = 1'b0;
  always @(posedge clk) begin
    if (!det_rst_n) begin
      m_word <= 8'h00; m_sreg <= 8'h00; m_armed <= 1'b0; m_fnd <= 1'b0;
    end else if (det_set_word) begin
      m_word <= det_word; m_sreg <= 8'h00; m_armed <= 1'b0; m_fnd <= 1'b0;
    end else begin
      if (det_start) m_armed <= 1'b1;
      if (m_armed) begin
        m_sreg <= {m_sreg[6:0], det_bit};
        if (m_sreg == m_word) m_fnd <= 1'b1;
      end
    end
  end
  assign det_found = m_fnd;

  typedef struct packed {
    logic        f;
    logic        u;
    logic [15:0] pos;
    logic        cp;   // compare match_pos only when a match is expected
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] src_q[$];
  int         bytes_acc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  int         lat;
  logic       rdy;
  int         n_done;

  function automatic exp_t mk_exp(logic f, logic u, logic [15:0] pos, logic cp);
    exp_t e;
    e.f = f; e.u = u; e.pos = pos; e.cp = cp;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_cmd(input logic [7:0] p, input logic [15:0] m);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_pattern = p; cmd_max_bits = m;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Returns cycles from the first sampled cycle after start_cmd to done (-1 on timeout).
  task automatic wait_done(output int l, output logic saw_rdy);
    l = -1; saw_rdy = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (in_ready) saw_rdy = 1'b1;
      if (done) begin l = i; break; end
    end
  endtask

  task automatic gap();
    src_q.delete();
    repeat (3) @(posedge clk);
    #1;
    bytes_acc = 0;
  endtask

  initial begin
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (done === 1'b1) begin
            if (sb_q.size() == 0) check("unexpected_done", done, 0);
            else begin
              e = sb_q.pop_front();
              check("done_found", found, e.f);
              check("done_underrun", underrun, e.u);
              if (e.cp) check("done_match_pos", match_pos, e.pos);
            end
          end
        end
      end
      begin : source
        logic acc;
        forever begin
          @(negedge clk);
          acc = in_valid && in_ready;
          @(posedge clk); #1;
          if (acc && src_q.size() > 0) begin
            void'(src_q.pop_front());
            bytes_acc++;
          end
          in_valid = src_q.size() > 0;
          in_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
        end
      end
      begin : stimulus
        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_found", found, 0);
        check("rst_underrun", underrun, 0);
        check("rst_match_pos", match_pos, 0);
        check("rst_det_rst_n", det_rst_n, 0);
        check("rst_det_ctl", {det_set_word, det_start, det_bit}, 0);
        check("rst_det_word", det_word, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_det_rst_n", det_rst_n, 1);

        // 0xA5 found at bit 7.
        src_q = '{8'hA5, 8'h00};
        sb_q.push_back(mk_exp(1'b1, 1'b0, 16'd7, 1'b1));
        start_cmd(8'hA5, 16'd16);
        wait_done(lat, rdy);
        check("a5_latency", lat, 15);
        gap();

        // 0x3C spanning a byte boundary, found at bit 11.
        src_q = '{8'h03, 8'hC0};
        sb_q.push_back(mk_exp(1'b1, 1'b0, 16'd11, 1'b1));
        start_cmd(8'h3C, 16'd16);
        wait_done(lat, rdy);
        check("3c_latency", lat, 19);
        gap();

        // No match: full budget plus drain, exactly two bytes consumed.
        src_q = '{8'h00, 8'h00, 8'h00};
        sb_q.push_back(mk_exp(1'b0, 1'b0, 16'd0, 1'b0));
        start_cmd(8'hFF, 16'd16);
        wait_done(lat, rdy);
        check("ff_latency", lat, 23);
        check("ff_bytes_consumed", bytes_acc, 2);
        check("ff_bytes_left", src_q.size(), 1);
        gap();

        // Starvation after the first byte.
        src_q = '{8'h81};
        sb_q.push_back(mk_exp(1'b0, 1'b1, 16'd0, 1'b0));
        start_cmd(8'h81, 16'd24);
        wait_done(lat, rdy);
        check("underrun_latency", lat, 13);
        gap();

        // Abort in STREAM, done one cycle later.
        src_q = '{8'hAA, 8'hAA, 8'hAA, 8'hAA};
        sb_q.push_back(mk_exp(1'b0, 1'b0, 16'd0, 1'b0));
        start_cmd(8'h0F, 16'd32);
        repeat (5) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_done(lat, rdy);
        check("abort_latency", lat, 1);
        gap();

        // Fresh search after abort: detector reset, load, arm sequence then match.
        src_q = '{8'h0F};
        sb_q.push_back(mk_exp(1'b1, 1'b0, 16'd7, 1'b1));
        start_cmd(8'h0F, 16'd8);
        @(negedge clk);
        check("drst_det_rst_n", det_rst_n, 0);
        check("drst_set_word", det_set_word, 0);
        @(negedge clk);
        check("load_det_rst_n", det_rst_n, 1);
        check("load_set_word", det_set_word, 1);
        check("load_det_word", det_word, 8'h0F);
        @(negedge clk);
        check("arm_det_start", det_start, 1);
        wait_done(lat, rdy);
        check("0f_latency", lat, 12);
        gap();

        // Zero budget: done right after LOAD, no byte requested.
        src_q = '{8'h11};
        sb_q.push_back(mk_exp(1'b0, 1'b0, 16'd0, 1'b0));
        start_cmd(8'h11, 16'd0);
        wait_done(lat, rdy);
        check("zero_latency", lat, 3);
        check("zero_in_ready_seen", rdy, 0);
        check("zero_bytes_consumed", bytes_acc, 0);
        gap();

        // Reset in the middle of STREAM: back to IDLE without a done pulse.
        src_q = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55};
        start_cmd(8'h99, 16'd64);
        repeat (6) @(posedge clk);
        #1;
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_det_rst_n", det_rst_n, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_in_ready", in_ready, 0);
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          if (done) n_done++;
        end
        check("midrst_no_done", n_done, 0);
        gap();

        check("scoreboard_drained", sb_q.size(), 0);
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
